// File: rtl/payload_engine_sched.sv
// Purpose: per-packet sequencer for a bank of regex match engines. It gates byte intake, clears, enables and flushes the engines, then reports the IDs of matching engines.
// Latency: DRAIN_CYC flush cycles after the last byte, one snapshot cycle, then the first record. Records follow at one per 2 cycles at best.
// Backpressure: s_ready is low outside IDLE/SCAN. Records hold stable while m_valid=1 and m_ready=0, and the engines stay frozen during that stall.
module payload_engine_sched #(
    parameter int NUM_ENG   = 16,
    parameter int ID_W      = 4,
    parameter int DRAIN_CYC = 2,
    parameter int PKT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic               eng_sod,
    output logic               eng_en,
    output logic               eng_flush,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ID_W-1:0]    m_id,
    output logic               m_none,
    output logic               m_last,
    output logic [PKT_W-1:0]   m_pkt,
    output logic               busy
);

    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_SCAN   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    localparam int              CNT_W      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

    logic [2:0]         state;
    logic [CNT_W-1:0]   drain_cnt;
    logic [PKT_W-1:0]   pkt_cnt;
    logic [NUM_ENG-1:0] snap;
    logic [NUM_ENG-1:0] snap_minus1;
    logic [ID_W-1:0]    low_id;
    logic               snap_zero;
    logic               one_left;
    logic               accept;

    // The engines advance only on accepted bytes while scanning. During the flush they run freely to push the last byte through their state registers.
    assign s_ready   = (state == ST_IDLE) || (state == ST_SCAN);
    assign eng_sod   = (state == ST_CLEAR);
    assign eng_flush = (state == ST_DRAIN);
    assign eng_en    = s_ready ? s_valid : (state == ST_DRAIN);
    assign busy      = (state != ST_IDLE);
    assign accept    = s_valid & s_ready;

    // Clearing the lowest set bit of the snapshot retires the engine that was just reported.
    assign snap_minus1 = snap - NUM_ENG'(1);
    assign snap_zero   = (snap == '0);
    assign one_left    = !snap_zero && ((snap & snap_minus1) == '0);

    // Priority encoder: finds the lowest-numbered engine still pending in the snapshot.
    always_comb begin
        low_id = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (snap[i]) begin
                low_id = ID_W'(i);
            end
        end
    end

    // Packet sequencer: handles scan, flush, snapshot and the serialised report of matching engines.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_CLEAR;
            drain_cnt <= '0;
            pkt_cnt   <= '0;
            snap      <= '0;
            m_valid   <= 1'b0;
            m_id      <= '0;
            m_none    <= 1'b0;
            m_last    <= 1'b0;
            m_pkt     <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    state <= ST_IDLE;
                end
                ST_IDLE, ST_SCAN: begin
                    if (accept) begin
                        if (s_last) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                            m_pkt     <= pkt_cnt;
                            pkt_cnt   <= pkt_cnt + PKT_W'(1);
                        end else begin
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        snap  <= eng_match;
                        state <= ST_REPORT;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (!m_valid) begin
                        // Present the next record. An empty snapshot yields a single "no match" record.
                        m_valid <= 1'b1;
                        m_none  <= snap_zero;
                        m_id    <= snap_zero ? '0 : low_id;
                        m_last  <= snap_zero || one_left;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        snap    <= snap & snap_minus1;
                        if (m_last) begin
                            state <= ST_CLEAR;
                        end
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payload_engine_sched.sv
// Bench for payload_engine_sched with a 4-engine bank and a 2-cycle drain.
// Expected records are queued when a packet is sent and compared as the DUT hands them off.
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_payload_engine_sched;

    localparam int NUM_ENG   = 4;
    localparam int ID_W      = 2;
    localparam int DRAIN_CYC = 2;
    localparam int PKT_W     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_valid;
    logic               s_last;
    logic               s_ready;
    logic               eng_sod;
    logic               eng_en;
    logic               eng_flush;
    logic [NUM_ENG-1:0] eng_match;
    logic               m_valid;
    logic               m_ready;
    logic [ID_W-1:0]    m_id;
    logic               m_none;
    logic               m_last;
    logic [PKT_W-1:0]   m_pkt;
    logic               busy;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             none;
        logic             last;
        logic [PKT_W-1:0] pkt;
    } rec_t;

    rec_t             exp_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [PKT_W-1:0] exp_pkt  = '0;

    always #5 clk = ~clk;

    payload_engine_sched #(
        .NUM_ENG(NUM_ENG), .ID_W(ID_W), .DRAIN_CYC(DRAIN_CYC), .PKT_W(PKT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .eng_sod(eng_sod), .eng_en(eng_en), .eng_flush(eng_flush),
        .eng_match(eng_match),
        .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id), .m_none(m_none),
        .m_last(m_last), .m_pkt(m_pkt), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Queue the records a packet with the given sticky match vector must produce.
    task automatic push_expected(input logic [NUM_ENG-1:0] match);
        rec_t r;
        int   hi;
        if (match == '0) begin
            r.id = '0; r.none = 1'b1; r.last = 1'b1; r.pkt = exp_pkt;
            exp_q.push_back(r);
        end else begin
            hi = 0;
            for (int i = 0; i < NUM_ENG; i++) if (match[i]) hi = i;
            for (int i = 0; i < NUM_ENG; i++) begin
                if (match[i]) begin
                    r.id = ID_W'(i); r.none = 1'b0; r.last = (i == hi); r.pkt = exp_pkt;
                    exp_q.push_back(r);
                end
            end
        end
        exp_pkt = exp_pkt + PKT_W'(1);
    endtask

    // Drive one packet (vpat bit i = valid on cycle i, last on the final cycle), then check flush timing and first-record latency.
    task automatic send_packet(input logic [7:0] vpat, input int len,
                               input logic [NUM_ENG-1:0] match, input string tag);
        for (int i = 0; i < len; i++) begin
            s_valid = vpat[i];
            s_last  = (i == len - 1);
            #1;
            checks++;
            if (s_ready !== 1'b1 || eng_en !== s_valid || eng_flush !== 1'b0 || eng_sod !== 1'b0) begin
                failures++;
                $display("FAIL %s_scan beat %0d: rdy=%b en=%b flush=%b sod=%b required rdy=1 en=%b flush=0 sod=0",
                         tag, i, s_ready, eng_en, eng_flush, eng_sod, s_valid);
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        push_expected(match);
        eng_match = match;
        for (int d = 0; d < DRAIN_CYC; d++) begin
            checks++;
            if ({eng_flush, eng_en, s_ready, m_valid} !== 4'b1100) begin
                failures++;
                $display("FAIL %s_drain cyc %0d: flush,en,rdy,mvld=%b required 1100",
                         tag, d, {eng_flush, eng_en, s_ready, m_valid});
            end
            tick();
        end
        checks++;
        if ({eng_flush, eng_en, s_ready, m_valid, busy} !== 5'b00001) begin
            failures++;
            $display("FAIL %s_report_entry: flush,en,rdy,mvld,busy=%b required 00001",
                     tag, {eng_flush, eng_en, s_ready, m_valid, busy});
        end
        tick();
        checks++;
        if (m_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_latency: m_valid=%b required 1", tag, m_valid);
        end
    endtask

    // Pop and compare every queued record. The first one is optionally stalled with m_ready low.
    task automatic collect(input int stall, input string tag);
        rec_t e;
        int   guard = 0;
        bit   first = 1'b1;
        while (exp_q.size() > 0 && guard < 40) begin
            guard++;
            if (m_valid !== 1'b1) begin
                tick();
                continue;
            end
            e = exp_q[0];
            if (first) begin
                for (int s = 0; s < stall; s++) begin
                    checks++;
                    if ({m_valid, m_id, m_last} !== {1'b1, e.id, e.last} || eng_en !== 1'b0 || s_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_stall cyc %0d: vld=%b id=%0d last=%b en=%b rdy=%b required vld=1 id=%0d last=%b en=0 rdy=0",
                                 tag, s, m_valid, m_id, m_last, eng_en, s_ready, e.id, e.last);
                    end
                    tick();
                end
            end
            first = 1'b0;
            checks++;
            if (m_id !== e.id || m_none !== e.none || m_last !== e.last || m_pkt !== e.pkt) begin
                failures++;
                $display("FAIL %s_record: id=%0d none=%b last=%b pkt=%h required id=%0d none=%b last=%b pkt=%h",
                         tag, m_id, m_none, m_last, m_pkt, e.id, e.none, e.last, e.pkt);
            end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            void'(exp_q.pop_front());
            checks++;
            if (m_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_post_handshake: m_valid=%b required 0", tag, m_valid);
            end
            if (e.last) begin
                checks++;
                if (eng_sod !== 1'b1 || s_ready !== 1'b0 || eng_en !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_clear: sod=%b rdy=%b en=%b required sod=1 rdy=0 en=0",
                             tag, eng_sod, s_ready, eng_en);
                end
                tick();
                eng_match = '0;
                checks++;
                if (eng_sod !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_idle: sod=%b rdy=%b busy=%b required sod=0 rdy=1 busy=0",
                             tag, eng_sod, s_ready, busy);
                end
            end
        end
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d records still pending, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; eng_match = '0;
        tick();
        tick();
        checks++;
        if ({eng_sod, s_ready, eng_en, eng_flush, m_valid, busy} !== 6'b100001 ||
            m_id !== '0 || m_none !== 1'b0 || m_last !== 1'b0 || m_pkt !== '0) begin
            failures++;
            $display("FAIL reset_clear: sod,rdy,en,flush,mvld,busy=%b id=%0d none=%b last=%b pkt=%h required 100001 0 0 0 0000",
                     {eng_sod, s_ready, eng_en, eng_flush, m_valid, busy}, m_id, m_none, m_last, m_pkt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({eng_sod, s_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL reset_idle: sod,rdy,busy=%b required 010", {eng_sod, s_ready, busy});
        end
        tick();
        checks++;
        if ({eng_sod, s_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL reset_idle_hold: sod,rdy,busy=%b required 010", {eng_sod, s_ready, busy});
        end
    endtask

    task automatic test_no_match();
        send_packet(8'b0001_1111, 5, 4'b0000, "nomatch");
        collect(0, "nomatch");
    endtask

    task automatic test_two_match();
        send_packet(8'b0000_0111, 3, 4'b1010, "two");
        collect(0, "two");
    endtask

    task automatic test_stall();
        send_packet(8'b0000_0111, 3, 4'b1010, "stall");
        collect(5, "stall");
    endtask

    task automatic test_bubbles();
        send_packet(8'b0001_1001, 5, 4'b0001, "bubble");
        collect(0, "bubble");
    endtask

    task automatic test_pkt_wrap();
        force dut.pkt_cnt = 16'hFFFF;
        tick();
        release dut.pkt_cnt;
        exp_pkt = 16'hFFFF;
        send_packet(8'b0000_0011, 2, 4'b0100, "wrap_ffff");
        collect(0, "wrap_ffff");
        send_packet(8'b0000_0001, 1, 4'b0000, "wrap_0000");
        collect(0, "wrap_0000");
    endtask

    task automatic test_reset_mid_report();
        send_packet(8'b0000_0111, 3, 4'b1010, "midrst");
        rst = 1'b1;
        tick();
        checks++;
        if ({m_valid, eng_sod, s_ready, busy} !== 4'b0101) begin
            failures++;
            $display("FAIL midrst_clear: mvld,sod,rdy,busy=%b required 0101", {m_valid, eng_sod, s_ready, busy});
        end
        rst = 1'b0;
        exp_q.delete();
        exp_pkt = '0;
        eng_match = '0;
        tick();
        checks++;
        if ({m_valid, eng_sod, s_ready, busy} !== 4'b0010) begin
            failures++;
            $display("FAIL midrst_idle: mvld,sod,rdy,busy=%b required 0010", {m_valid, eng_sod, s_ready, busy});
        end
        send_packet(8'b0000_0011, 2, 4'b0001, "after_rst");
        collect(0, "after_rst");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_no_match();
        test_two_match();
        test_stall();
        test_bubbles();
        test_pkt_wrap();
        test_reset_mid_report();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
